// File: rtl/fast_nms.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fast_nms : 3x3 non-maximum suppression for a FAST corner raster stream
// Rev 1.0
// ---------------------------------------------------------------------------
module fast_nms #(
  parameter int COL_NUM     = 640,
  parameter int ROW_NUM     = 480,
  parameter int SCORE_WIDTH = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   iscorner,
  input  logic [9:0]             x_coord,
  input  logic [9:0]             y_coord,
  input  logic [SCORE_WIDTH-1:0] score,
  output logic                   nms_vld,
  output logic                   nms_corner,
  output logic [9:0]             nms_x,
  output logic [9:0]             nms_y,
  output logic [SCORE_WIDTH-1:0] nms_score
);

  localparam int         AW    = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam logic [9:0] X_MAX = 10'(COL_NUM - 2);
  localparam logic [9:0] Y_MAX = 10'(ROW_NUM - 2);

  logic [SCORE_WIDTH-1:0] lb1 [COL_NUM];
  logic [SCORE_WIDTH-1:0] lb2 [COL_NUM];
  logic [SCORE_WIDTH-1:0] win [3][3];
  logic [9:0]             cx;
  logic [9:0]             cy;
  logic                   s1_vld;

  logic [AW-1:0]          idx;
  logic [SCORE_WIDTH-1:0] eff;
  logic [SCORE_WIDTH-1:0] lb1_rd;
  logic [SCORE_WIDTH-1:0] lb2_rd;
  logic [SCORE_WIDTH-1:0] centre;
  logic                   earlier_ok;
  logic                   later_ok;
  logic                   interior;

  assign idx    = x_coord[AW-1:0];
  assign eff    = iscorner ? score : '0;
  assign lb1_rd = lb1[idx];
  assign lb2_rd = lb2[idx];

  // Line buffers carry no reset; border suppression hides any stale content.
  always_ff @(posedge clk) begin
    if (ce && !rst) begin
      lb2[idx] <= lb1_rd;
      lb1[idx] <= eff;
    end
  end

  // Strict against raster-earlier neighbours, non-strict against later ones,
  // so the raster-first pixel of an equal plateau is the only survivor.
  always_comb begin
    centre     = win[1][1];
    earlier_ok = (centre > win[0][0]) && (centre > win[0][1]) &&
                 (centre > win[0][2]) && (centre > win[1][0]);
    later_ok   = (centre >= win[1][2]) && (centre >= win[2][0]) &&
                 (centre >= win[2][1]) && (centre >= win[2][2]);
    interior   = s1_vld && (cx >= 10'd1) && (cx <= X_MAX) &&
                 (cy >= 10'd1) && (cy <= Y_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
      cx         <= '0;
      cy         <= '0;
      s1_vld     <= 1'b0;
      nms_vld    <= 1'b0;
      nms_corner <= 1'b0;
      nms_x      <= '0;
      nms_y      <= '0;
      nms_score  <= '0;
    end else if (ce) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2]  <= lb2_rd;
      win[1][2]  <= lb1_rd;
      win[2][2]  <= eff;
      cx         <= x_coord - 10'd1;
      cy         <= y_coord - 10'd1;
      s1_vld     <= 1'b1;
      nms_vld    <= interior;
      nms_corner <= interior && (centre != '0) && earlier_ok && later_ok;
      nms_x      <= cx;
      nms_y      <= cy;
      nms_score  <= centre;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fast_nms.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fast_nms : directed frames with a queued scoreboard and edge-timed monitor
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fast_nms;

  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int SW   = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic          iscorner = 1'b0;
  logic [9:0]    x_coord = '0;
  logic [9:0]    y_coord = '0;
  logic [SW-1:0] score = '0;
  logic          nms_vld;
  logic          nms_corner;
  logic [9:0]    nms_x;
  logic [9:0]    nms_y;
  logic [SW-1:0] nms_score;

  fast_nms #(.COL_NUM(COLS), .ROW_NUM(ROWS), .SCORE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .iscorner(iscorner),
    .x_coord(x_coord), .y_coord(y_coord), .score(score),
    .nms_vld(nms_vld), .nms_corner(nms_corner), .nms_x(nms_x),
    .nms_y(nms_y), .nms_score(nms_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          corner;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [SW-1:0] score;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   edge_cnt = 0;

  // Frame image (effective scores) and the hand-picked surviving corners.
  int img [ROWS][COLS];
  bit corner_map [ROWS][COLS];

  task automatic clear_frame();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        img[r][c] = 0;
        corner_map[r][c] = 1'b0;
      end
  endtask

  task automatic drive(input logic c, input int x, input int y, input logic ic,
                       input int sc);
    exp_t e;
    @(negedge clk);
    rst      = 1'b0;
    ce       = c;
    x_coord  = 10'(x);
    y_coord  = 10'(y);
    iscorner = ic;
    score    = SW'(sc);
    if (c) begin
      n_acc++;
      if (x >= 2 && y >= 2) begin
        e.corner = corner_map[y-1][x-1];
        e.x      = 10'(x - 1);
        e.y      = 10'(y - 1);
        e.score  = SW'(img[y-1][x-1]);
        e.due    = n_acc + 1;
        exp_q.push_back(e);
      end
    end
  endtask

  // Non-corner samples carry random scores, which must be masked to zero.
  task automatic sample(input int x, input int y, input bit toggle);
    int v;
    v = img[y][x];
    if (v != 0) drive(1'b1, x, y, 1'b1, v);
    else        drive(1'b1, x, y, 1'b0, int'($urandom_range(1, 8191)));
    if (toggle)
      drive(1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
            1'b1, int'($urandom_range(1, 8191)));
  endtask

  task automatic run_frame(input bit toggle);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        sample(x, y, toggle);
  endtask

  task automatic check(input exp_t e, input int now);
    n_cmp++;
    if (nms_corner !== e.corner || nms_x !== e.x || nms_y !== e.y ||
        nms_score !== e.score || now != e.due) begin
      n_bad++;
      $display("FAIL out(%0d,%0d): got corner=%0b x=%0d y=%0d score=%0d edge=%0d, want corner=%0b x=%0d y=%0d score=%0d edge=%0d",
               e.x, e.y, nms_corner, nms_x, nms_y, nms_score, now,
               e.corner, e.x, e.y, e.score, e.due);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic adv;
    logic rs;
    logic have_cur;
    exp_t cur;
    have_cur = 1'b0;
    forever begin
      @(posedge clk);
      adv = ce && !rst;
      rs  = rst;
      #1;
      if (rs) begin
        have_cur = 1'b0;
        n_cmp++;
        if (nms_vld !== 1'b0 || nms_corner !== 1'b0 || nms_x !== '0 ||
            nms_y !== '0 || nms_score !== '0) begin
          n_bad++;
          $display("FAIL reset_state: got vld=%0b corner=%0b x=%0d y=%0d score=%0d, want all 0",
                   nms_vld, nms_corner, nms_x, nms_y, nms_score);
        end
      end else if (adv) begin
        edge_cnt++;
        if (nms_vld) begin
          if (exp_q.size() == 0) begin
            have_cur = 1'b0;
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_vld: got x=%0d y=%0d at edge %0d, want no output",
                     nms_x, nms_y, edge_cnt);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            check(cur, edge_cnt);
          end
        end else begin
          have_cur = 1'b0;
          if (exp_q.size() != 0 && exp_q[0].due <= edge_cnt) begin
            cur = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_vld: got vld=0 at edge %0d, want centre (%0d,%0d)",
                     edge_cnt, cur.x, cur.y);
          end
        end
      end else if (nms_vld) begin
        // ce low: the previous decision must hold unchanged.
        if (have_cur) check(cur, cur.due);
        else begin
          n_cmp++;
          n_bad++;
          $display("FAIL hold_vld: got vld=1 while idle, want 0");
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);

    // All-zero frame: 84 interior decisions, none a corner.
    clear_frame();
    run_frame(1'b0);

    // Single corner.
    clear_frame();
    img[5][5] = 50; corner_map[5][5] = 1'b1;
    run_frame(1'b0);

    // Plateau and diagonal neighbour.
    clear_frame();
    img[5][5] = 30; img[5][6] = 30; corner_map[5][5] = 1'b1;
    img[3][10] = 31; img[4][11] = 20; corner_map[3][10] = 1'b1;
    run_frame(1'b0);

    // Border corners suppress themselves and their interior neighbour.
    clear_frame();
    img[3][0] = 200; img[7][15] = 200; img[3][1] = 10;
    run_frame(1'b0);

    // Single corner with ce toggling.
    clear_frame();
    img[5][5] = 50; corner_map[5][5] = 1'b1;
    run_frame(1'b1);

    // Reset mid-frame at sample (8,4), then a full frame.
    clear_frame();
    img[2][5] = 77; corner_map[2][5] = 1'b1;
    for (int y = 0; y <= 4; y++)
      for (int x = 0; x < COLS; x++)
        if (y < 4 || x < 8) sample(x, y, 1'b0);
    @(negedge clk);
    rst = 1'b1; ce = 1'b1; x_coord = 10'd8; y_coord = 10'd4;
    // The decision for sample (7,4) would land on the reset edge and is lost.
    void'(exp_q.pop_back());
    run_frame(1'b0);

    // One trailing sample flushes the final decision; it is itself a border.
    drive(1'b1, 0, 0, 1'b0, 0);
    repeat (4) drive(1'b0, 0, 0, 1'b0, 0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d outstanding, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
